fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 Parameter LOG2N, default 8: FFT size N = 2^LOG2N; legal range 2..8.
REQ-002 Parameter BF_LAT, default 3: butterfly latency, bf_start to bf_valid, in cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to run a full in-place FFT.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse after the last write of the last stage.
REQ-008 rd_en  output  1  sample RAM read strobe.
REQ-009 rd_addr1, rd_addr2  output  8 each  read addresses.
REQ-010 rd_data1, rd_data2  input  64 each  {imag,real} Q24.8; valid 1 cycle after rd_en.
REQ-011 tw_addr  output  7  twiddle ROM address; issued in the same cycle as rd_en.
REQ-012 tw_data  input  64  ROM data; valid 1 cycle after tw_addr.
REQ-013 bf_start  output  1  butterfly issue strobe.
REQ-014 bf_idx1, bf_idx2  output  8 each  butterfly index tags.
REQ-015 bf_x1, bf_x2, bf_tw  output  64 each  butterfly operands.
REQ-016 bf_valid  input  1  butterfly result strobe.
REQ-017 bf_oidx1, bf_oidx2  input  8 each  returned index tags.
REQ-018 bf_y1, bf_y2  input  64 each  butterfly results.
REQ-019 wr_en  output  1  sample RAM dual write strobe.
REQ-020 wr_addr1, wr_addr2  output  8 each  write addresses.
REQ-021 wr_data1, wr_data2  output  64 each  write data.

Function
REQ-022 FSM states: IDLE, ISSUE, DRAIN, FIN.
REQ-023 IDLE->ISSUE when start=1; stage s=0, butterfly counter k=0.
REQ-024 start while not IDLE is ignored.
REQ-025 ISSUE: one rd_en per cycle, k=0..N/2-1, no gaps.
REQ-026 Addresses per issue: half=2^s, pos=k mod half; rd_addr1=(k>>s)*2*half+pos; rd_addr2=rd_addr1+half; tw_addr=pos<<(LOG2N-1-s); unused high bits are 0.
REQ-027 After k=N/2-1 is issued, ISSUE->DRAIN.
REQ-028 bf_start asserts exactly 1 cycle after each rd_en: bf_x1/bf_x2 = rd_data1/rd_data2, bf_tw = tw_data, bf_idx1/bf_idx2 = that cycle's registered addresses.
REQ-029 All bf_* outputs are registered-equivalent; operand values when bf_start=0 are don't-care.
REQ-030 Write-back on bf_valid=1 (any state except IDLE): next cycle wr_en=1, wr_addr1/wr_addr2 = bf_oidx1/bf_oidx2, wr_data1/wr_data2 = bf_y1/bf_y2.
REQ-031 bf_valid in IDLE is ignored; no wr_en results.
REQ-032 Outstanding counter (width >= LOG2N): +1 on rd_en, -1 on wr_en; both in the same cycle leaves it unchanged.
REQ-033 DRAIN exits when outstanding=0 and no rd_en, bf_start, bf_valid or wr_en is in flight.
REQ-034 DRAIN exit, s<LOG2N-1: s+1, k=0, ->ISSUE; the first rd_en of stage s+1 is strictly after the last wr_en of stage s (in-place RAW hazard).
REQ-035 DRAIN exit, s=LOG2N-1: ->FIN.
REQ-036 FIN: done=1 for one cycle, busy=0 from the same cycle, ->IDLE.
REQ-037 Sample RAM holds input in bit-reversed order before start; output is natural order.
REQ-038 No arithmetic on data: operands and results pass unmodified.

Reset
REQ-039 rst_n=0 forces IDLE and s=k=outstanding=0 immediately.
REQ-040 During reset, every output is 0: busy, done, rd_en, bf_start, wr_en, all addresses and data.
REQ-041 Reset mid-run abandons the FFT; in-flight results are not written; the next start begins at stage 0.

Verification
REQ-042 LOG2N=3, start: stage0 rd pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0; stage1 (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
REQ-043 LOG2N=3 with a BF_LAT=3 butterfly model: rd_en high 4 consecutive cycles/stage; bf_start lags rd_en by 1; wr_en lags bf_start by 4; next stage rd_en is after the last wr_en; done pulses once; busy falls with done.
REQ-044 LOG2N=3, impulse at address 0 (value 1.0 = 0x100 real), reference butterfly model: all 8 output bins = 0x100 real, 0 imag.
REQ-045 start re-pulsed while busy: address sequence unchanged, exactly one done.
REQ-046 rst_n low during stage 1: outputs 0 the same cycle; no wr_en afterwards; a new start replays from stage 0 pairs (0,1).
REQ-047 bf_valid pulsed in IDLE: wr_en stays 0.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks stages/butterflies, feeds an external
// butterfly unit from the sample RAM and twiddle ROM, and writes results back.
module fft_stage_ctrl #(
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [7:0]  rd_addr1,
  output logic [7:0]  rd_addr2,
  input  logic [63:0] rd_data1,
  input  logic [63:0] rd_data2,
  output logic [6:0]  tw_addr,
  input  logic [63:0] tw_data,
  output logic        bf_start,
  output logic [7:0]  bf_idx1,
  output logic [7:0]  bf_idx2,
  output logic [63:0] bf_x1,
  output logic [63:0] bf_x2,
  output logic [63:0] bf_tw,
  input  logic        bf_valid,
  input  logic [7:0]  bf_oidx1,
  input  logic [7:0]  bf_oidx2,
  input  logic [63:0] bf_y1,
  input  logic [63:0] bf_y2,
  output logic        wr_en,
  output logic [7:0]  wr_addr1,
  output logic [7:0]  wr_addr2,
  output logic [63:0] wr_data1,
  output logic [63:0] wr_data2
);

  localparam int HALF_N = 1 << (LOG2N - 1);
  // Outstanding never exceeds min(N/2, pipeline depth); size for whichever is larger.
  localparam int INFL_W = $clog2(BF_LAT + 3);
  localparam int OW     = ((LOG2N > INFL_W) ? LOG2N : INFL_W) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic        en;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [63:0] d1;
    logic [63:0] d2;
  } wr_req_t;

  state_t        state_q, state_d;
  logic [2:0]    s_q, s_d;
  logic [7:0]    k_q, k_d;
  logic [OW-1:0] out_q;
  logic          bf_start_q;
  logic [7:0]    bf_idx1_q, bf_idx2_q;
  wr_req_t       wr_q;

  logic [7:0] half, pos, base, a1;
  logic [3:0] sh_hi, sh_tw;
  logic [6:0] tw_sh;
  logic       drain_clear;

  // Butterfly k of stage s pairs (a1, a1+2^s) inside group k>>s.
  always_comb begin
    half  = 8'd1 << s_q;
    pos   = k_q & (half - 8'd1);
    sh_hi = {1'b0, s_q} + 4'd1;
    base  = (k_q >> s_q) << sh_hi;
    a1    = base | pos;
    sh_tw = 4'(LOG2N - 1) - {1'b0, s_q};
    tw_sh = 7'(pos) << sh_tw;
  end

  assign rd_en    = (state_q == ISSUE);
  assign rd_addr1 = rd_en ? a1 : '0;
  assign rd_addr2 = rd_en ? (a1 | half) : '0;
  assign tw_addr  = rd_en ? tw_sh : '0;

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == FIN);

  // RAM/ROM read data is already registered, so operands are forwarded in the bf_start cycle.
  assign bf_start = bf_start_q;
  assign bf_idx1  = bf_idx1_q;
  assign bf_idx2  = bf_idx2_q;
  assign bf_x1    = bf_start_q ? rd_data1 : '0;
  assign bf_x2    = bf_start_q ? rd_data2 : '0;
  assign bf_tw    = bf_start_q ? tw_data  : '0;

  assign wr_en    = wr_q.en;
  assign wr_addr1 = wr_q.a1;
  assign wr_addr2 = wr_q.a2;
  assign wr_data1 = wr_q.d1;
  assign wr_data2 = wr_q.d2;

  // Nothing may remain in flight before the next stage reads the same RAM locations.
  assign drain_clear = (out_q == '0) && !rd_en && !bf_start_q && !bf_valid && !wr_q.en;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        s_d     = '0;
        k_d     = '0;
      end
      ISSUE: begin
        k_d = k_q + 8'd1;
        if (k_q == 8'(HALF_N - 1)) state_d = DRAIN;
      end
      DRAIN: if (drain_clear) begin
        if (s_q == 3'(LOG2N - 1)) begin
          state_d = FIN;
        end else begin
          state_d = ISSUE;
          s_d     = s_q + 3'd1;
          k_d     = '0;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_start_q <= 1'b0;
      bf_idx1_q  <= '0;
      bf_idx2_q  <= '0;
    end else begin
      bf_start_q <= rd_en;
      bf_idx1_q  <= rd_addr1;
      bf_idx2_q  <= rd_addr2;
    end
  end

  // Results arriving in IDLE belong to an abandoned run and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
    end else begin
      wr_q.en <= bf_valid && (state_q != IDLE);
      if (bf_valid && (state_q != IDLE)) begin
        wr_q.a1 <= bf_oidx1;
        wr_q.a2 <= bf_oidx2;
        wr_q.d1 <= bf_y1;
        wr_q.d2 <= bf_y2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_q + {{(OW-1){1'b0}}, rd_en} - {{(OW-1){1'b0}}, wr_q.en};
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl at N=8: RAM/ROM/butterfly models around the DUT,
// expected address order from the textbook FFT loop nest, impulse-response end check.
module tb_fft_stage_ctrl;
  localparam int LOG2N  = 3;
  localparam int BF_LAT = 3;
  localparam int N      = 8;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, rd_en, bf_start, bf_valid, wr_en;
  logic [7:0]  rd_addr1, rd_addr2, bf_idx1, bf_idx2, bf_oidx1, bf_oidx2, wr_addr1, wr_addr2;
  logic [6:0]  tw_addr;
  logic [63:0] rd_data1 = '0, rd_data2 = '0, tw_data = '0;
  logic [63:0] bf_x1, bf_x2, bf_tw, bf_y1, bf_y2, wr_data1, wr_data2;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .tw_addr(tw_addr), .tw_data(tw_data),
    .bf_start(bf_start), .bf_idx1(bf_idx1), .bf_idx2(bf_idx2),
    .bf_x1(bf_x1), .bf_x2(bf_x2), .bf_tw(bf_tw),
    .bf_valid(bf_valid), .bf_oidx1(bf_oidx1), .bf_oidx2(bf_oidx2),
    .bf_y1(bf_y1), .bf_y2(bf_y2),
    .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2)
  );

  // sample RAM and twiddle ROM models (1-cycle read latency)
  logic [63:0] ram [256];
  logic [63:0] rom [128];
  logic [63:0] init_mem [N];
  logic        load = 1'b0;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < N; i++) ram[i] <= init_mem[i];
    else if (wr_en) begin
      ram[wr_addr1] <= wr_data1;
      ram[wr_addr2] <= wr_data2;
    end
    if (rd_en) begin
      rd_data1 <= ram[rd_addr1];
      rd_data2 <= ram[rd_addr2];
    end
    tw_data <= rom[tw_addr];
  end

  // complex Q24.8 butterfly: y1 = a + w*b, y2 = a - w*b
  function automatic logic [127:0] bfly(input logic [63:0] a, input logic [63:0] b, input logic [63:0] w);
    longint ar, ai, br, bi, wr, wi, pr, pim;
    logic [31:0] y1r, y1i, y2r, y2i;
    ar = longint'($signed(a[31:0])); ai = longint'($signed(a[63:32]));
    br = longint'($signed(b[31:0])); bi = longint'($signed(b[63:32]));
    wr = longint'($signed(w[31:0])); wi = longint'($signed(w[63:32]));
    pr  = (br * wr - bi * wi) >>> 8;
    pim = (br * wi + bi * wr) >>> 8;
    y1r = 32'(ar + pr);  y1i = 32'(ai + pim);
    y2r = 32'(ar - pr);  y2i = 32'(ai - pim);
    return {y1i, y1r, y2i, y2r};
  endfunction

  logic [BF_LAT-1:0] pv = '0;
  logic [7:0]  pi1 [BF_LAT], pi2 [BF_LAT];
  logic [63:0] py1 [BF_LAT], py2 [BF_LAT];
  logic        inj = 1'b0;
  logic [7:0]  inj_i1 = '0, inj_i2 = '0;
  logic [63:0] inj_y = '0;

  always @(posedge clk) begin
    pv <= {pv[BF_LAT-2:0], bf_start};
    pi1[0] <= bf_idx1;
    pi2[0] <= bf_idx2;
    {py1[0], py2[0]} <= bfly(bf_x1, bf_x2, bf_tw);
    for (int i = 1; i < BF_LAT; i++) begin
      pi1[i] <= pi1[i-1]; pi2[i] <= pi2[i-1];
      py1[i] <= py1[i-1]; py2[i] <= py2[i-1];
    end
  end

  assign bf_valid = pv[BF_LAT-1] | inj;
  assign bf_oidx1 = inj ? inj_i1 : pi1[BF_LAT-1];
  assign bf_oidx2 = inj ? inj_i2 : pi2[BF_LAT-1];
  assign bf_y1    = inj ? inj_y  : py1[BF_LAT-1];
  assign bf_y2    = inj ? ~inj_y : py2[BF_LAT-1];

  typedef struct {int s; int k; logic [7:0] a1; logic [7:0] a2; logic [6:0] tw;} rd_t;
  typedef struct {logic [7:0] i1; logic [7:0] i2; logic [63:0] x1; logic [63:0] x2; logic [63:0] tw;} bf_t;
  typedef struct {logic [7:0] a1; logic [7:0] a2; logic [63:0] d1; logic [63:0] d2;} wr_t;

  rd_t exp_rd[$];
  bf_t exp_bf[$];
  wr_t exp_wr[$];

  int checks = 0, errors = 0, done_cnt = 0;
  bit wb_expect = 1'b0, seen_s1 = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  // expected read order from the classic group/offset loop nest
  task automatic push_expected();
    int kk;
    for (int s = 0; s < LOG2N; s++) begin
      int span = 1 << s;
      kk = 0;
      for (int g = 0; g < N; g += 2 * span)
        for (int j = 0; j < span; j++) begin
          exp_rd.push_back('{s: s, k: kk, a1: 8'(g + j), a2: 8'(g + j + span), tw: 7'(j * (N / (2 * span)))});
          kk++;
        end
    end
  endtask

  // monitor
  initial begin
    int tb_out = 0;
    bit prev_rd = 1'b0, prev_bfv = 1'b0;
    rd_t e; bf_t b; wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tb_out = 0; prev_rd = 1'b0; prev_bfv = 1'b0;
      end else begin
        if (bf_start || prev_rd) chk("bf_lag", bf_start, prev_rd);
        if (wr_en || prev_bfv) chk("wr_lag", wr_en, prev_bfv);
        if (rd_en) begin
          if (exp_rd.size() == 0) fail("rd_unexpected");
          else begin
            e = exp_rd.pop_front();
            chk("rd_addr", {rd_addr1, rd_addr2, tw_addr}, {e.a1, e.a2, e.tw});
            if (e.k == 0) chk("rd_raw", {tb_out == 0, wr_en}, 2'b10);
            else          chk("rd_gap", prev_rd, 1'b1);
            if (e.s == 1) seen_s1 = 1'b1;
            exp_bf.push_back('{i1: rd_addr1, i2: rd_addr2, x1: ram[rd_addr1], x2: ram[rd_addr2], tw: rom[tw_addr]});
          end
        end
        if (bf_start) begin
          if (exp_bf.size() == 0) fail("bf_unexpected");
          else begin
            b = exp_bf.pop_front();
            chk("bf_idx", {bf_idx1, bf_idx2}, {b.i1, b.i2});
            chk("bf_ops", {bf_x1, bf_x2, bf_tw}, {b.x1, b.x2, b.tw});
          end
        end
        if (wr_en) begin
          if (exp_wr.size() == 0) fail("wr_unexpected");
          else begin
            w = exp_wr.pop_front();
            chk("wr_data", {wr_addr1, wr_addr2, wr_data1, wr_data2}, {w.a1, w.a2, w.d1, w.d2});
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", busy, 1'b0);
        end
        if (bf_valid && wb_expect) exp_wr.push_back('{a1: bf_oidx1, a2: bf_oidx2, d1: bf_y1, d2: bf_y2});
        tb_out += int'(rd_en) - int'(wr_en);
        prev_rd  = rd_en;
        prev_bfv = bf_valid && wb_expect;
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, {busy, done, rd_en, bf_start, wr_en}, '0);
    chk({nm, "_addr"}, {rd_addr1, rd_addr2, tw_addr, bf_idx1, bf_idx2, wr_addr1, wr_addr2}, '0);
    chk({nm, "_data"}, |{bf_x1, bf_x2, bf_tw, wr_data1, wr_data2}, 1'b0);
  endtask

  task automatic load_mem(input bit impulse);
    for (int i = 0; i < N; i++)
      init_mem[i] = impulse ? ((i == 0) ? 64'h100 : 64'h0) : {$urandom, $urandom};
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic pulse_start(input bit push);
    @(posedge clk); #1 start = 1'b1;
    if (push) push_expected();
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_fft(input bit repulse);
    bit got = 1'b0;
    done_cnt = 0; wb_expect = 1'b1;
    pulse_start(1'b1);
    chk("busy_on", busy, 1'b1);
    if (repulse) begin
      repeat (3) @(posedge clk);
      pulse_start(1'b0);
    end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) fail("done_timeout");
    repeat (8) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("busy_off", busy, 1'b0);
    chk("queues_empty", exp_rd.size() + exp_bf.size() + exp_wr.size(), 0);
    wb_expect = 1'b0;
  endtask

  initial begin
    bit wr_seen;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {32'h0000_0000, 32'h0000_0100};
    rom[1] = {32'hFFFF_FF4B, 32'h0000_00B5};
    rom[2] = {32'hFFFF_FF00, 32'h0000_0000};
    rom[3] = {32'hFFFF_FF4B, 32'hFFFF_FF4B};

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // impulse, with a spurious start while busy
    load_mem(1'b1);
    run_fft(1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("bin%0d", i), ram[i], 64'h100);

    load_mem(1'b0);
    run_fft(1'b0);

    // result strobe while idle must not write
    @(posedge clk); #1 inj = 1'b1; inj_i1 = 8'($urandom_range(0, 7)); inj_i2 = 8'($urandom_range(0, 7)); inj_y = {$urandom, $urandom};
    @(posedge clk); #1 inj = 1'b0;
    wr_seen = 1'b0;
    repeat (6) begin @(negedge clk); wr_seen |= wr_en; end
    chk("idle_bfv_no_wr", wr_seen, 1'b0);

    // reset during stage 1 abandons the run
    load_mem(1'b0);
    done_cnt = 0; wb_expect = 1'b1; seen_s1 = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 200 && !seen_s1; i++) @(negedge clk);
    if (!seen_s1) fail("stage1_timeout");
    @(posedge clk); #2 wb_expect = 1'b0; rst_n = 1'b0;
    #1 check_zero("reset_mid");
    exp_rd.delete(); exp_bf.delete(); exp_wr.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    wr_seen = 1'b0;
    repeat (10) begin @(negedge clk); wr_seen |= wr_en; end
    chk("abandon_no_wr", wr_seen, 1'b0);
    chk("abandon_no_done", done_cnt, 0);

    load_mem(1'b0);
    run_fft(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
